// File: rtl/toggle_rx_fifo.sv
// Toggle-handshake receiver: a byte offered by each get_it toggle is captured into
// a small FIFO and acknowledged by toggling put_it; the FIFO drains on data_valid/data_ready.
module toggle_rx_fifo #(
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               shared,
  input  logic                     get_it,
  output logic                     put_it,
  output logic [7:0]               data_out,
  output logic                     data_valid,
  input  logic                     data_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     proto_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic {IDLE, WAIT_SPACE} state_t;

  state_t                  state;
  logic [SYNC_STAGES-1:0]  sync_pipe;
  logic                    sync_req, sync_nxt;
  logic                    seen_phase, seen_nxt;
  logic                    pending, push, pop;
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [DEPTH-1:0][7:0]   mem;
  logic [CW-1:0]           count_nxt;

  assign sync_req   = sync_pipe[SYNC_STAGES-1];
  assign sync_nxt   = sync_pipe[SYNC_STAGES-2];
  assign pending    = sync_req != seen_phase;
  // state is WAIT_SPACE exactly when a request is pending against a full FIFO,
  // so gating on IDLE is the "count < DEPTH before this edge's pop" rule.
  assign push       = pending && (state == IDLE);
  assign data_valid = count != '0;
  assign pop        = data_valid && data_ready;
  assign data_out   = mem[rd_ptr];
  assign put_it     = seen_phase;
  assign count_nxt  = count + CW'(push) - CW'(pop);
  assign seen_nxt   = seen_phase ^ push;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_pipe  <= '0;
      seen_phase <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      mem        <= '0;
      proto_err  <= 1'b0;
      state      <= IDLE;
    end else begin
      sync_pipe  <= {sync_pipe[SYNC_STAGES-2:0], get_it};
      seen_phase <= seen_nxt;
      count      <= count_nxt;
      if (push) begin
        mem[wr_ptr] <= shared;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      // A second toggle before the ack cancels the pending phase; flag it for good.
      if (pending && (sync_nxt != sync_req))
        proto_err <= 1'b1;
      state <= ((sync_nxt != seen_nxt) && (count_nxt == FULL)) ? WAIT_SPACE : IDLE;
    end
  end
endmodule
